// File: rtl/column_step_scheduler.sv
// Single-clock step scheduler for the falling-letter columns: issues one-cycle
// step enables, staggers column release and shortens the step period with score.
module column_step_scheduler #(
    parameter int NUM_COLS      = 3,
    parameter int BASE_DIV      = 25_000_000,
    parameter int DIV_STEP      = 2_500_000,
    parameter int MIN_DIV       = 5_000_000,
    parameter int STAGGER_STEPS = 10,
    parameter int MAX_LEVEL     = 7
) (
    input  logic                clock,
    input  logic                reset_signal,
    input  logic                start,
    input  logic                pause,
    input  logic [7:0]          score,
    input  logic [NUM_COLS-1:0] game_over,
    input  logic [NUM_COLS-1:0] correct,
    output logic [NUM_COLS-1:0] step_en,
    output logic [NUM_COLS-1:0] col_active,
    output logic [3:0]          speed_level,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  w_running;
    logic                  w_stepAllowed;

    logic [31:0]           r_prescaler;
    logic [31:0]           r_period;
    logic [31:0]           w_periodNext;
    int                    w_periodSub;
    logic                  w_tick;

    logic [3:0]            r_speedLevel;
    logic [3:0]            w_levelNext;
    logic [7:0]            r_stepCount;

    logic [NUM_COLS-1:0]   r_colActive;
    logic [NUM_COLS-1:0]   r_skip;
    logic [NUM_COLS-1:0]   r_stepEn;
    logic [NUM_COLS-1:0]   w_release;
    logic [NUM_COLS-1:0]   w_activeNext;
    logic [NUM_COLS-1:0]   w_fire;
    logic [NUM_COLS-1:0]   w_tickMask;

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN: begin
                if (|game_over)  w_nextState = OVER;
                else if (pause)  w_nextState = PAUSE;
            end
            PAUSE: begin
                if (|game_over)  w_nextState = OVER;
                else if (!pause) w_nextState = RUN;
            end
            OVER:    w_nextState = OVER;
            default: w_nextState = IDLE;
        endcase
    end

    // A step is only emitted if we are still in RUN on the cycle it appears.
    always_comb begin
        w_running     = (r_state == RUN);
        w_stepAllowed = (w_nextState == RUN);
        state         = r_state;
    end

    assign w_tick = w_running && (r_prescaler == (r_period - 32'd1));

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_prescaler <= '0;
        end else if (w_running) begin
            r_prescaler <= w_tick ? 32'd0 : (r_prescaler + 32'd1);
        end
    end

    always_comb begin
        w_levelNext = score[7:4];
        if (int'(score[7:4]) > MAX_LEVEL) begin
            w_levelNext = 4'(MAX_LEVEL);
        end
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_speedLevel <= '0;
        end else begin
            r_speedLevel <= w_levelNext;
        end
    end

    // Period only changes on a tick so a running step always completes at its old length.
    always_comb begin
        w_periodSub  = BASE_DIV - (int'(r_speedLevel) * DIV_STEP);
        w_periodNext = 32'(w_periodSub);
        if (w_periodSub < MIN_DIV) begin
            w_periodNext = 32'(MIN_DIV);
        end
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_period <= 32'(BASE_DIV);
        end else if (w_tick) begin
            r_period <= w_periodNext;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_stepCount <= '0;
        end else if (w_tick && (r_stepCount != 8'hFF)) begin
            r_stepCount <= r_stepCount + 8'd1;
        end
    end

    always_comb begin
        w_release = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            w_release[k] = w_tick && (int'(r_stepCount) == (k * STAGGER_STEPS));
        end
        w_activeNext = r_colActive | w_release;
        w_tickMask   = w_tick ? w_activeNext : '0;
        w_fire       = w_tickMask & ~r_skip;
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_colActive <= '0;
            r_skip      <= '0;
            r_stepEn    <= '0;
        end else begin
            r_colActive <= w_activeNext;
            r_skip      <= (r_skip & ~w_tickMask) | correct;
            r_stepEn    <= w_stepAllowed ? w_fire : '0;
        end
    end

    assign step_en     = r_stepEn;
    assign col_active  = r_colActive;
    assign speed_level = r_speedLevel;

endmodule
